// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the ICE front-end elastic buffers.
// Default word/depth sizes, pointer-width helper and the per-cycle operation encoding.
package ram_fifo_pkg;

   localparam int unsigned ICE_DATA_WIDTH = 8;
   localparam int unsigned ICE_DEPTH_LOG2 = 4;

   // One extra pointer bit acts as the wrap flag that separates full from empty.
   function automatic int unsigned ptr_width(input int unsigned depth_log2);
      return depth_log2 + 1;
   endfunction

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/ram_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the FIFO pointers decide what is meaningful.
module ram_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy count,
// almost-full flag and a high-water mark of the peak occupancy.
module ram_fifo
   import ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = ICE_DATA_WIDTH,
   parameter int unsigned DEPTH_LOG2   = ICE_DEPTH_LOG2,
   parameter int unsigned AFULL_THRESH = (1 << DEPTH_LOG2) - 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  almost_full_o,
   output logic [DEPTH_LOG2:0]   high_water_o
);

   localparam int unsigned    PW        = ptr_width(DEPTH_LOG2);
   localparam logic [PW-1:0]  ONE       = PW'(1);
   localparam logic [PW-1:0]  AFULL_CNT = PW'(AFULL_THRESH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;
   logic [PW-1:0] hw_q, hw_d;
   logic          empty, full, push, pop;
   fifo_op_e      op;

   // Flags come only from registered pointers, so no comb path from the handshake inputs.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) &&
                  (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

   assign in_ready_o    = !full;
   assign out_valid_o   = !empty;
   assign almost_full_o = (count_q >= AFULL_CNT);
   assign count_o       = count_q;
   assign high_water_o  = hw_q;

   assign push = in_valid_i && in_ready_o;
   assign pop  = out_valid_o && out_ready_i;
   assign op   = fifo_op_e'({push, pop});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         case (op)
            OP_PUSH: begin
               wr_ptr_d = wr_ptr_q + ONE;
               count_d  = count_q + ONE;
            end
            OP_POP: begin
               rd_ptr_d = rd_ptr_q + ONE;
               count_d  = count_q - ONE;
            end
            OP_BOTH: begin
               wr_ptr_d = wr_ptr_q + ONE;
               rd_ptr_d = rd_ptr_q + ONE;
            end
            default: ;
         endcase
      end
      hw_d = flush_i ? '0 : ((count_d > hw_q) ? count_d : hw_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hw_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hw_q     <= hw_d;
      end
   end

   ram_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_fifo_ram (
      .clk_i     (clk_i),
      .wr_en_i   (push && !flush_i),
      .wr_addr_i (wr_ptr_q[PW-2:0]),
      .wr_data_i (in_data_i),
      .rd_addr_i (rd_ptr_q[PW-2:0]),
      .rd_data_o (out_data_o)
   );

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo (8-bit words, 16 deep, almost-full at 14).
module tb_ram_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] count;
   logic       almost_full;
   logic [4:0] high_water;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_fifo #(
      .DATA_WIDTH   (8),
      .DEPTH_LOG2   (4),
      .AFULL_THRESH (14)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .in_data_i     (in_data),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .out_data_o    (out_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .count_o       (count),
      .almost_full_o (almost_full),
      .high_water_o  (high_water)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   logic [7:0] model_q[$];
   int         sent, rcvd, cycles;
   logic       drv_v, drv_r, exp_push, exp_pop;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_afull", almost_full, 0);
      rst_n = 1'b1;
      tick();

      // 1: reset dropped while a burst of three pushes is in progress
      in_valid = 1'b1;
      in_data = 8'h01; tick();
      in_data = 8'h02; tick();
      chk("t1_pre_count", count, 2);
      in_data = 8'h03;
      #2 rst_n = 1'b0;
      #1;
      chk("t1_count", count, 0);
      chk("t1_out_valid", out_valid, 0);
      chk("t1_in_ready", in_ready, 1);
      chk("t1_hw", high_water, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      in_data = 8'h21; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t1_post_valid", out_valid, 1);
      chk("t1_post_data", out_data, 8'h21);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t1_drained", count, 0);

      // 2: fill to full, then a refused 17th push
      for (int i = 0; i < 16; i++) begin
         push_word(8'(i));
         if (i == 12) chk("t2_afull_13", almost_full, 0);
         if (i == 13) chk("t2_afull_14", almost_full, 1);
         if (i == 14) chk("t2_ready_15", in_ready, 1);
      end
      chk("t2_in_ready", in_ready, 0);
      chk("t2_count16", count, 16);
      push_word(8'hAA);
      chk("t2_count_refused", count, 16);
      chk("t2_hw", high_water, 16);
      chk("t2_head", out_data, 8'h00);

      // 3: drain from full
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3_valid", out_valid, 1);
         chk("t3_data", out_data, i);
         tick();
      end
      out_ready = 1'b0;
      chk("t3_empty", out_valid, 0);
      chk("t3_count", count, 0);
      chk("t3_hw", high_water, 16);

      // 4: simultaneous push+pop in mid, empty and full states
      for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
      chk("t4_count5", count, 5);
      in_data = 8'h45; in_valid = 1'b1; out_ready = 1'b1; tick();
      in_valid = 1'b0;
      chk("t4_mid_count", count, 5);
      chk("t4_mid_head", out_data, 8'h41);
      for (int i = 0; i < 5; i++) tick();
      chk("t4_drained", count, 0);
      in_data = 8'h55; in_valid = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t4_empty_count", count, 1);
      chk("t4_empty_valid", out_valid, 1);
      chk("t4_empty_data", out_data, 8'h55);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push_word(8'h60 + 8'(i));
      in_data = 8'h99; in_valid = 1'b1; out_ready = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t4_full_count", count, 15);
      chk("t4_full_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("t4_full_data", out_data, 8'h60 + i);
         tick();
      end
      out_ready = 1'b0;
      chk("t4_full_empty", out_valid, 0);

      // 5: 40-word stream with random stalls against a queue model
      sent = 0; rcvd = 0; cycles = 0;
      while (rcvd < 40 && cycles < 2000) begin
         drv_v = (sent < 40) && ($urandom_range(0, 2) != 0);
         drv_r = ($urandom_range(0, 2) != 0);
         chk("t5_in_ready", in_ready, (model_q.size() < 16) ? 1 : 0);
         chk("t5_out_valid", out_valid, (model_q.size() > 0) ? 1 : 0);
         chk("t5_count", count, model_q.size());
         exp_push = drv_v && (model_q.size() < 16);
         exp_pop  = drv_r && (model_q.size() > 0);
         if (exp_pop) chk("t5_data", out_data, model_q[0]);
         in_data  = 8'h80 + 8'(sent);
         in_valid = drv_v;
         out_ready = drv_r;
         tick();
         if (exp_pop) begin
            void'(model_q.pop_front());
            rcvd++;
         end
         if (exp_push) begin
            model_q.push_back(8'h80 + 8'(sent));
            sent++;
         end
         cycles++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t5_received", rcvd, 40);
      chk("t5_final_count", count, 0);

      // 6: flush wins over a concurrent push and pop
      for (int i = 0; i < 7; i++) push_word(8'h30 + 8'(i));
      chk("t6_count7", count, 7);
      flush = 1'b1; in_data = 8'h77; in_valid = 1'b1; out_ready = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("t6_count", count, 0);
      chk("t6_hw", high_water, 0);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      push_word(8'h88);
      chk("t6_next_data", out_data, 8'h88);
      chk("t6_next_count", count, 1);
      chk("t6_next_hw", high_water, 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t6_after_pop", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
